// File: rtl/aud_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aud_pkg : shared types, limits and reciprocal table for the playback DSP
// Rev 1.0
// ---------------------------------------------------------------------------
package aud_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_FAST   = 2'd1,
    MODE_SLOW0  = 2'd2,
    MODE_SLOW1  = 2'd3
  } aud_mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_CALC  = 3'd3,
    S_PAUSE = 3'd4
  } aud_state_e;

  localparam int SPEED_MAX = 8;
  localparam int RECIP_SH  = 23;

  typedef logic signed [15:0] sample_t;

  // ceil(2^23 / s): rounding up keeps the truncated quotient exact for |p| < 2^20
  function automatic logic [23:0] recip(input logic [3:0] s);
    logic [23:0] r;
    case (s)
      4'd2:    r = 24'd4194304;
      4'd3:    r = 24'd2796203;
      4'd4:    r = 24'd2097152;
      4'd5:    r = 24'd1677722;
      4'd6:    r = 24'd1398102;
      4'd7:    r = 24'd1198373;
      4'd8:    r = 24'd1048576;
      default: r = 24'd8388608;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aud_interp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aud_interp : linear interpolation prev + ((cur-prev)*k)/speed, combinational
// Rev 1.0
// ---------------------------------------------------------------------------
module aud_interp
  import aud_pkg::*;
(
  input  sample_t    prev,
  input  sample_t    cur,
  input  logic [3:0] k,
  input  logic [3:0] speed,
  output sample_t    y
);

  logic signed [16:0] diff;
  logic signed [20:0] k_ext;
  logic signed [20:0] prod;
  logic        [19:0] mag;
  logic        [43:0] scaled;
  logic        [19:0] quot;
  logic signed [20:0] q_s;
  logic signed [16:0] sum;

  always_comb begin
    diff   = 17'(cur) - 17'(prev);
    k_ext  = {17'd0, k};
    prod   = 21'(diff) * k_ext;
    // divide the magnitude so the result truncates toward zero
    mag    = prod[20] ? 20'(-prod) : prod[19:0];
    scaled = 44'(mag) * 44'(recip(speed));
    quot   = 20'(scaled >> RECIP_SH);
    q_s    = $signed({1'b0, quot});
    if (prod[20]) begin
      q_s = -q_s;
    end
    sum    = 17'(prev) + 17'(q_s);
    y      = sum[15:0];
  end

endmodule
`default_nettype wire

// File: rtl/aud_rate_dsp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aud_rate_dsp : SRAM sample playback with normal/fast/slow/interpolated rates
// Rev 1.0
// ---------------------------------------------------------------------------
module aud_rate_dsp
  import aud_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int SPEED_MAX = aud_pkg::SPEED_MAX
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_daclrck,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  aud_mode_e         i_mode,
  input  logic [3:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [15:0]       i_sram_data,
  output sample_t           o_dac_data,
  output logic              o_en,
  output logic              o_done
);

  aud_state_e        state;
  aud_state_e        next_state;

  logic              lrck_q;
  logic              tick;
  logic [ADDR_W-1:0] addr;
  sample_t           dac;
  logic              done;
  logic [3:0]        k;
  sample_t           prev;
  sample_t           cur;
  aud_mode_e         mode_r;
  logic [3:0]        speed_r;
  logic              last;
  logic              pause_pend;

  logic [3:0]        speed_eff;
  logic              slow;
  logic              k_wrap;
  logic [3:0]        k_next;
  logic [3:0]        step;
  logic              adv;
  logic [ADDR_W:0]   next_addr;
  logic              past_end;
  logic              need_fetch;
  logic              end_now;
  sample_t           interp_y;
  sample_t           calc_out;

  assign tick = lrck_q & ~i_daclrck;

  always_comb begin
    speed_eff = i_speed;
    if (i_speed == 4'd0) begin
      speed_eff = 4'd1;
    end else if (i_speed > 4'(SPEED_MAX)) begin
      speed_eff = 4'(SPEED_MAX);
    end
  end

  always_comb begin
    slow       = (mode_r == MODE_SLOW0) || (mode_r == MODE_SLOW1);
    k_wrap     = (k == (speed_r - 4'd1));
    k_next     = k_wrap ? 4'd0 : (k + 4'd1);
    step       = (mode_r == MODE_FAST) ? speed_r : 4'd1;
    adv        = !slow || k_wrap;
    next_addr  = {1'b0, addr} + {{(ADDR_W-3){1'b0}}, step};
    past_end   = next_addr > {1'b0, i_end_addr};
    need_fetch = !slow || (k == 4'd0);
    calc_out   = (mode_r == MODE_SLOW1) ? interp_y : cur;
    end_now    = (state == S_WAIT) && !i_stop && !i_pause && tick && last;
  end

  aud_interp u_interp (
    .prev  (prev),
    .cur   (cur),
    .k     (k),
    .speed (speed_r),
    .y     (interp_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (i_stop) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_start && !i_pause) next_state = S_WAIT;
        S_WAIT: begin
          if (i_pause) begin
            next_state = S_PAUSE;
          end else if (tick) begin
            next_state = last ? S_IDLE : S_READ;
          end
        end
        S_READ:  next_state = S_CALC;
        S_CALC:  next_state = (i_pause || pause_pend) ? S_PAUSE : S_WAIT;
        S_PAUSE: if (i_start && !i_pause) next_state = S_WAIT;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_en        = (state != S_IDLE);
    o_sram_addr = addr;
    o_dac_data  = dac;
    o_done      = done;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lrck_q     <= 1'b1;
      addr       <= '0;
      dac        <= '0;
      done       <= 1'b0;
      k          <= 4'd0;
      prev       <= '0;
      cur        <= '0;
      mode_r     <= MODE_NORMAL;
      speed_r    <= 4'd1;
      last       <= 1'b0;
      pause_pend <= 1'b0;
    end else begin
      lrck_q <= i_daclrck;
      done   <= end_now;
      if (next_state == S_IDLE) begin
        addr       <= '0;
        dac        <= '0;
        k          <= 4'd0;
        prev       <= '0;
        cur        <= '0;
        last       <= 1'b0;
        pause_pend <= 1'b0;
      end else begin
        case (state)
          S_WAIT: begin
            if (tick && !i_pause) begin
              mode_r  <= i_mode;
              speed_r <= speed_eff;
              if ((i_mode != mode_r) || (speed_eff != speed_r)) begin
                k <= 4'd0;
              end
              if ((i_mode == MODE_SLOW1) && (mode_r != MODE_SLOW1)) begin
                prev <= cur;
              end
            end
          end
          S_READ: begin
            pause_pend <= i_pause;
            if (need_fetch) begin
              prev <= cur;
              cur  <= i_sram_data;
            end
          end
          S_CALC: begin
            pause_pend <= 1'b0;
            dac        <= calc_out;
            k          <= slow ? k_next : 4'd0;
            if (adv) begin
              if (past_end) begin
                last <= 1'b1;
              end else begin
                addr <= next_addr[ADDR_W-1:0];
              end
            end
          end
          default: ;
        endcase
        // the paused output is silent even when a calculation just finished
        if (next_state == S_PAUSE) begin
          dac <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_rate_dsp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aud_rate_dsp : directed vector bench for aud_rate_dsp
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_aud_rate_dsp;
  import aud_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        daclrck = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  aud_mode_e   mode = MODE_NORMAL;
  logic [3:0]  speed = 4'd1;
  logic [19:0] end_addr = 20'd0;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  sample_t     dac_data;
  logic        en;
  logic        done;

  logic [15:0] mem [32];

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    aud_mode_e   mode;
    logic [3:0]  speed;
    logic [19:0] end_addr;
    int          pat;
    int          n;
    int          exp [8];
  } vec_t;

  typedef struct {
    logic        done1;
    logic        done2;
    logic        en1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic [19:0] a3;
  } tick_t;

  vec_t vecs [8];

  aud_rate_dsp #(.ADDR_W(20), .SPEED_MAX(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_daclrck   (daclrck),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_mode      (mode),
    .i_speed     (speed),
    .i_end_addr  (end_addr),
    .o_sram_addr (sram_addr),
    .i_sram_data (sram_data),
    .o_dac_data  (dac_data),
    .o_en        (en),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    sram_data <= mem[sram_addr[4:0]];
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input int pat);
    for (int i = 0; i < 32; i++) begin
      mem[i] = 16'(i);
    end
    case (pat)
      1: begin mem[0] = 16'd100; mem[1] = 16'd200; end
      2: begin mem[0] = 16'd0;   mem[1] = 16'(-100); end
      3: begin mem[0] = 16'd0;   mem[1] = 16'd100; end
      default: ;
    endcase
  endtask

  task automatic add_vec(input int idx, input aud_mode_e m, input int sp, input int ea,
                         input int pat, input int n, input int e0, input int e1,
                         input int e2, input int e3, input int e4, input int e5,
                         input int e6, input int e7);
    vecs[idx].mode     = m;
    vecs[idx].speed    = 4'(sp);
    vecs[idx].end_addr = 20'(ea);
    vecs[idx].pat      = pat;
    vecs[idx].n        = n;
    vecs[idx].exp[0] = e0; vecs[idx].exp[1] = e1; vecs[idx].exp[2] = e2; vecs[idx].exp[3] = e3;
    vecs[idx].exp[4] = e4; vecs[idx].exp[5] = e5; vecs[idx].exp[6] = e6; vecs[idx].exp[7] = e7;
  endtask

  // falling LRCK right after an edge; the detect cycle starts at that edge
  task automatic do_tick(output tick_t t);
    @(posedge clk); #1 daclrck = 1'b0;
    @(posedge clk); #1 t.done1 = done; t.en1 = en;
    @(posedge clk); #1 t.d2 = dac_data; t.done2 = done;
    @(posedge clk); #1 t.d3 = dac_data; t.a3 = sram_addr;
    daclrck = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    tick_t t;
    int    prev_exp;

    add_vec(0, MODE_NORMAL, 1,  3, 0, 4, 0, 1, 2, 3, 0, 0, 0, 0);
    add_vec(1, MODE_FAST,   3,  9, 0, 4, 0, 3, 6, 9, 0, 0, 0, 0);
    add_vec(2, MODE_SLOW0,  2,  1, 1, 4, 100, 100, 200, 200, 0, 0, 0, 0);
    add_vec(3, MODE_SLOW1,  4,  1, 2, 8, 0, 0, 0, 0, 0, -25, -50, -75);
    add_vec(4, MODE_SLOW1,  3,  1, 3, 6, 0, 0, 0, 0, 33, 66, 0, 0);
    add_vec(5, MODE_SLOW1,  3,  1, 2, 6, 0, 0, 0, 0, -33, -66, 0, 0);
    add_vec(6, MODE_FAST,   0,  2, 0, 3, 0, 1, 2, 0, 0, 0, 0, 0);
    add_vec(7, MODE_FAST,  12, 16, 0, 3, 0, 8, 16, 0, 0, 0, 0, 0);

    load_mem(0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_en",   int'(en), 0);
    check("rst_addr", int'(sram_addr), 0);
    check("rst_data", int'(dac_data), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int v = 0; v < 8; v++) begin
      load_mem(vecs[v].pat);
      mode     = vecs[v].mode;
      speed    = vecs[v].speed;
      end_addr = vecs[v].end_addr;
      pulse_start();
      #1 check($sformatf("v%0d_en_start", v), int'(en), 1);
      for (int i = 0; i < vecs[v].n; i++) begin
        prev_exp = (i == 0) ? 0 : vecs[v].exp[i-1];
        do_tick(t);
        check($sformatf("v%0d_hold%0d", v, i), int'($signed(t.d2)), prev_exp);
        check($sformatf("v%0d_out%0d", v, i), int'($signed(t.d3)), vecs[v].exp[i]);
        check($sformatf("v%0d_nodone%0d", v, i), int'(t.done1), 0);
      end
      do_tick(t);
      check($sformatf("v%0d_done", v), int'(t.done1), 1);
      check($sformatf("v%0d_done_pulse", v), int'(t.done2), 0);
      check($sformatf("v%0d_en_end", v), int'(t.en1), 0);
      check($sformatf("v%0d_idle_data", v), int'($signed(t.d3)), 0);
      check($sformatf("v%0d_idle_addr", v), int'(t.a3), 0);
    end

    // pause after two samples, hold for five ticks, then resume
    load_mem(0);
    mode = MODE_NORMAL; speed = 4'd1; end_addr = 20'd7;
    pulse_start();
    do_tick(t); check("p_out0", int'($signed(t.d3)), 0);
    do_tick(t); check("p_out1", int'($signed(t.d3)), 1);
    @(posedge clk); #1 pause = 1'b1;
    @(posedge clk); #1 pause = 1'b0;
    check("p_en", int'(en), 1);
    for (int i = 0; i < 5; i++) begin
      do_tick(t);
      check($sformatf("p_hold_data%0d", i), int'($signed(t.d3)), 0);
      check($sformatf("p_hold_addr%0d", i), int'(t.a3), 2);
    end
    pulse_start();
    do_tick(t);
    check("p_resume_data", int'($signed(t.d3)), 2);
    check("p_resume_addr", int'(t.a3), 3);

    // stop, pause and start together: stop wins
    @(posedge clk); #1 stop = 1'b1; pause = 1'b1; start = 1'b1;
    @(posedge clk); #1 stop = 1'b0; pause = 1'b0; start = 1'b0;
    check("sps_en",   int'(en), 0);
    check("sps_addr", int'(sram_addr), 0);
    check("sps_data", int'(dac_data), 0);
    check("sps_done", int'(done), 0);
    repeat (3) @(posedge clk);

    // reset asserted while the FSM is in S_CALC
    pulse_start();
    do_tick(t); check("r_out0", int'($signed(t.d3)), 0);
    @(posedge clk); #1 daclrck = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; daclrck = 1'b1;
    check("r_data", int'(dac_data), 0);
    check("r_addr", int'(sram_addr), 0);
    check("r_en",   int'(en), 0);
    check("r_done", int'(done), 0);
    @(posedge clk); #1;
    check("r_done_after", int'(done), 0);
    check("r_en_after",   int'(en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aud_rate_dsp.md
AUD_RATE_DSP -- requirements
Module: aud_rate_dsp

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter SPEED_MAX, default 8, largest legal speed factor.
REQ-003 i_clk  in  1  DAC bit clock (BCLK); the only clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_daclrck  in  1  DAC LR clock, synchronous to i_clk.
REQ-006 i_start / i_pause / i_stop  in  1 each  playback commands, level-sampled per cycle.
REQ-007 i_mode  in  2  playback mode, aud_mode_e (NORMAL, FAST, SLOW0, SLOW1).
REQ-008 i_speed  in  4  speed factor; 0 is treated as 1, values above SPEED_MAX as SPEED_MAX.
REQ-009 i_end_addr  in  ADDR_W  last valid sample address, inclusive.
REQ-010 o_sram_addr  out  ADDR_W  SRAM read address, registered.
REQ-011 i_sram_data  in  16  SRAM read data, valid one cycle after o_sram_addr changes.
REQ-012 o_dac_data  out  16  signed sample to the downstream DAC serializer.
REQ-013 o_en  out  1  serializer enable.
REQ-014 o_done  out  1  one-cycle pulse at end of data.

Function
REQ-015 States: S_IDLE, S_WAIT, S_READ, S_CALC, S_PAUSE.
REQ-016 Tick: falling edge of i_daclrck, detected with a registered copy (prev=1, cur=0).
REQ-017 o_en is 1 in every state except S_IDLE.
REQ-018 S_IDLE: o_sram_addr=0, o_dac_data=0; i_start -> S_WAIT.
REQ-019 S_WAIT: tick -> S_READ.
REQ-020 S_READ: capture i_sram_data as cur when a new sample is needed, copying old cur to prev; then S_CALC.
REQ-021 S_CALC: o_dac_data updates, address and sub-step counter k advance, then S_WAIT.
REQ-022 o_dac_data updates on the clock edge exactly 3 cycles after the tick-detect cycle and holds until the next update.
REQ-023 NORMAL: output cur; address +1 per tick.
REQ-024 FAST: output cur; address +speed per tick.
REQ-025 SLOW0: output cur; k counts 0..speed-1; address +1 only when k wraps to 0.
REQ-026 SLOW1: output prev + ((cur-prev)*k)/speed.
REQ-027 SLOW1 arithmetic: 17-bit signed difference, 21-bit signed product, division truncates toward zero, result fits 16 bits without saturation.
REQ-028 SLOW1: address +1 and new fetch on k wrap; on entry to SLOW1, prev=cur.
REQ-029 i_mode and i_speed are sampled only in S_WAIT at the tick; a change takes effect on the next tick and resets k to 0.
REQ-030 End: if the next address would exceed i_end_addr, the current output is still produced, then o_done pulses one cycle and the FSM enters S_IDLE.
REQ-031 Pause: i_pause in S_WAIT/S_READ/S_CALC completes any in-progress S_CALC, then enters S_PAUSE.
REQ-032 S_PAUSE: o_dac_data=0; address and k are held; i_start resumes to S_WAIT.
REQ-033 Stop: i_stop in any state -> S_IDLE next cycle, address=0, o_dac_data=0, no o_done.
REQ-034 Same-cycle command priority: stop > pause > start.

Reset
REQ-035 On i_rst: state=S_IDLE, o_sram_addr=0, o_dac_data=0, o_en=0, o_done=0, k=0, prev=cur=0, LRCK copy=1.
REQ-036 Reset mid-playback behaves like stop, with no o_done.

Structure
REQ-037 Package aud_pkg holds aud_mode_e, the state enum, SPEED_MAX, and the 16-bit sample type.
REQ-038 Sub-module aud_interp is combinational: prev, cur, k, speed -> interpolated sample, using a reciprocal table (no iterative divider).

Verification
REQ-039 NORMAL, SRAM[n]=n, end=3, start -> outputs 0,1,2,3 on successive ticks, each 3 cycles after the tick; o_done after 3; o_en=0.
REQ-040 FAST speed 3, end=9 -> outputs SRAM[0],[3],[6],[9]; then o_done.
REQ-041 SLOW0 speed 2, SRAM={100,200} -> 100,100,200,200.
REQ-042 SLOW1 speed 4, SRAM={0,-100,...}: prev=0, cur=-100 -> 0,-25,-50,-75; also speed 3, diff 100 -> 0,33,66.
REQ-043 Pause after 2 ticks holds o_dac_data=0 and o_sram_addr for 5 ticks; start resumes at the held address. Stop+pause+start in one cycle -> S_IDLE.
REQ-044 i_rst during S_CALC -> all outputs 0 next cycle, no o_done; i_speed=0 behaves as 1; i_speed=12 behaves as 8.
